muldiv_seq: RTL
===============

# muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide instructions. It reuses the core's single shared 32-bit ALU and owns no adder of its own: every add, subtract and negate goes through the ALU port, and shifts are done in local registers. It sits beside the execute stage. The pipeline starts an operation, then stalls on `busy` until the one-cycle `done` pulse.

## Interface
- `XLEN`, 32, operand/result width (only 32 supported)
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — asynchronous, active-high reset
- `start` input 1 — request; sampled only when `busy`=0
- `op` input 3 — RV32M funct3: 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU; 001/010/011 illegal
- `a` input 32 — rs1 operand, captured on accepted start
- `b` input 32 — rs2 operand, captured on accepted start
- `busy` output 1 — operation in flight
- `done` output 1 — one-cycle pulse; `result` valid this cycle and held afterwards
- `result` output 32 — final value, held until the next accepted start
- `alu_func` output 4 — ALU function select: 0000 add, 1000 sub
- `alu_in0` output 32 — ALU operand 0
- `alu_in1` output 32 — ALU operand 1
- `alu_out` input 32 — combinational ALU result, consumed in the same cycle

## Operation
- States: IDLE → NEGA → NEGB → LOOP (32 iterations, 5-bit counter 0..31) → NEGR → DONE → IDLE.
- All ops take every state. Latency is fixed, independent of operands.
- IDLE with `start`=1:
  - Capture `a`, `b`, `op`.
  - Record `sa`/`sb` = operand sign bits for signed ops (DIV/REM), else 0.
  - Go to NEGA; `busy`=1 from the next cycle.
- NEGA: drive sub, in0=0, in1=A. Store `alu_out` into A if `sa`, else keep A.
- NEGB: same, for B with `sb`.
- LOOP, MUL (shift-add, P = 32-bit accumulator, A shifts left, B shifts right):
  - Drive add(P, A).
  - Take P=`alu_out` if B[0], else keep P.
  - Then A<<=1, B>>=1.
  - Low 32 bits only, wrap modulo 2^32.
- LOOP, divide (restoring; R = remainder, Q = dividend/quotient shift register):
  - Form R' = {R[30:0], Q[31]}; Q<<=1.
  - Drive sub(R', B). Since R' and B are 32-bit values, the borrow (R' < B) is determined by unsigned comparison of R' and B — no 33rd bit is required.
  - If R' ≥ B unsigned: R=`alu_out`, Q[0]=1; else R=R', Q[0]=0.
- NEGR:
  - Negate the quotient if `sa`^`sb` (DIV), or the remainder if `sa` (REM), via sub(0, x).
  - Otherwise drive add(x, 0).
- DONE: load `result`, pulse `done`, drop `busy`, return to IDLE.
- Special results (override in DONE, RISC-V semantics):
  - b=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
  - DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM of same → 0.
  - Illegal op → 0.
- IDLE/DONE drive `alu_func`=0000, `alu_in0`=`alu_in1`=0.
- `start` while `busy`=1 is ignored; no queuing.
- `start` in the DONE cycle is ignored. Accepts resume the cycle after.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE, `alu_func`=0000, `alu_in0`=`alu_in1`=0.
- `rst` mid-operation: immediate abort to IDLE with the reset values above. No `done` pulse for the aborted op.
- Start accepted at edge E0:
  - `busy`=1 for the 35 cycles after E0.
  - `done`=1 in cycle 36 (NEGA 1 + NEGB 1 + LOOP 32 + NEGR 1 + DONE 1).
  - `busy`=0 in the `done` cycle.
- Back-to-back throughput: one op per 37 cycles.
- ALU path is combinational in one cycle: drive `alu_*` from state registers, register `alu_out` at the next edge.
- All outputs are registered except `alu_*`, which are decoded from state registers only.

## Test plan
- MUL: a=7, b=6 → `done` exactly 36 cycles after start, result=42. Also a=0xFFFFFFFF, b=0xFFFFFFFF → 0x00000001.
- DIVU/REMU: a=100, b=7 → 14 and 2. DIV a=-100 (0xFFFFFF9C), b=7 → 0xFFFFFFF2. REM same → 0xFFFFFFFE.
- Divide by zero: DIVU a=5, b=0 → 0xFFFFFFFF. REM a=0xFFFFFFF6, b=0 → 0xFFFFFFF6.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM same → 0. Illegal op=001 → 0 after 36 cycles.
- Handshake: hold `start`=1 continuously with changing operands. Only the operands at accepted edges count: first op at E0, second at E0+37. `result` holds between `done` pulses.
- Reset mid-LOOP (cycle 10): `busy`/`done`/`result` go to 0 immediately, no `done` follows. A fresh MUL 3×4 afterwards → 12.

Source files
------------

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer. It borrows the core's shared ALU for every
// add, subtract and negate, so its latency is fixed regardless of operand values.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [3:0]      alu_func,
    output logic [XLEN-1:0] alu_in0,
    output logic [XLEN-1:0] alu_in1,
    input  logic [XLEN-1:0] alu_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_NEGA, S_NEGB, S_LOOP, S_NEGR, S_DONE
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            sa_q, sa_d, sb_q, sb_d;
    logic            bzero_q, bzero_d;
    logic [XLEN-1:0] a_q, a_d;      // MUL multiplicand / divide dividend-quotient
    logic [XLEN-1:0] b_q, b_d;      // MUL multiplier / divisor
    logic [XLEN-1:0] p_q, p_d;      // MUL accumulator / divide remainder
    logic [4:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            is_mul, is_rem, is_quot, is_illegal, neg_r;
    logic [XLEN-1:0] rem_shift, neg_src;
    logic            rem_ge;

    assign is_mul     = (op_q == 3'b000);
    assign is_quot    = op_q[2] & ~op_q[1];
    assign is_rem     = op_q[2] &  op_q[1];
    assign is_illegal = ~op_q[2] & (op_q[1:0] != 2'b00);
    assign neg_r      = is_rem ? sa_q : (is_quot & (sa_q ^ sb_q));
    assign neg_src    = is_quot ? a_q : p_q;
    assign rem_shift  = {p_q[XLEN-2:0], a_q[XLEN-1]};
    assign rem_ge     = (rem_shift >= b_q);

    // ALU drive is decoded from state registers only, so alu_out settles within the cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first; a path that skips an
        // assignment would otherwise infer a latch.
        alu_func = ALU_ADD;
        alu_in0  = '0;
        alu_in1  = '0;
        unique case (state_q)
            S_NEGA: begin alu_func = ALU_SUB; alu_in1 = a_q; end
            S_NEGB: begin alu_func = ALU_SUB; alu_in1 = b_q; end
            S_LOOP: begin
                if (is_mul) begin
                    alu_in0 = p_q;
                    alu_in1 = a_q;
                end else begin
                    alu_func = ALU_SUB;
                    alu_in0  = rem_shift;
                    alu_in1  = b_q;
                end
            end
            S_NEGR: begin
                if (neg_r) begin
                    alu_func = ALU_SUB;
                    alu_in1  = neg_src;
                end else begin
                    alu_in0 = neg_src;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: blocking assignments here; only the register process below uses <=.
        state_d  = state_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bzero_d  = bzero_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    sa_d    = op[2] & ~op[0] & a[XLEN-1];
                    sb_d    = op[2] & ~op[0] & b[XLEN-1];
                    bzero_d = (b == '0);
                    a_d     = a;
                    b_d     = b;
                    p_d     = '0;
                    state_d = S_NEGA;
                end
            end
            S_NEGA: begin
                if (sa_q) a_d = alu_out;
                state_d = S_NEGB;
            end
            S_NEGB: begin
                if (sb_q) b_d = alu_out;
                cnt_d   = '0;
                state_d = S_LOOP;
            end
            S_LOOP: begin
                if (is_mul) begin
                    if (b_q[0]) p_d = alu_out;
                    a_d = a_q << 1;
                    b_d = b_q >> 1;
                end else begin
                    p_d = rem_ge ? alu_out : rem_shift;
                    a_d = {a_q[XLEN-2:0], rem_ge};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_NEGR;
            end
            S_NEGR: begin
                // Signed overflow (MIN / -1) and remainder-by-zero already fall out of the
                // magnitude datapath; only quotient-by-zero and illegal ops need forcing.
                if (is_illegal)             result_d = '0;
                else if (is_quot & bzero_q) result_d = '1;
                else                        result_d = alu_out;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_NEGA) || (state_d == S_NEGB) ||
                 (state_d == S_LOOP) || (state_d == S_NEGR);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bzero_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bzero_q  <= bzero_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
